// File: rtl/tree_node_loader.sv
// Writer side of one tree level's node RAM: takes a byte-serial update frame,
// freezes lookups via update_req/update_gnt, and writes assembled node words.
module tree_node_loader #(
  parameter int NODE_WIDTH = 40,
  parameter int NODE_ADDR  = 6,
  parameter int BYTE_W     = 8,
  parameter int LEVEL_ID   = 3
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  update_req,
  input  logic                  update_gnt,
  output logic                  mem_we,
  output logic [NODE_ADDR-1:0]  mem_addr,
  output logic [NODE_WIDTH-1:0] mem_din,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int BPW = NODE_WIDTH / BYTE_W;
  localparam logic [BYTE_W:0] DEPTH = (BYTE_W+1)'(1 << NODE_ADDR);

  typedef enum logic [2:0] {
    IDLE, H_ADDR, H_CNT, REQ, PAYLOAD, WRITE, DRAIN, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            level_q, level_d;
  logic [BYTE_W-1:0]     addr_q, addr_d;
  logic [BYTE_W-1:0]     cnt_q, cnt_d;
  logic [NODE_WIDTH-1:0] word_q, word_d;
  logic [3:0]            idx_q, idx_d;
  logic [11:0]           drain_q, drain_d;
  logic                  err_q, err_d;
  logic [NODE_ADDR-1:0]  mem_addr_q, mem_addr_d;
  logic [NODE_WIDTH-1:0] mem_din_q, mem_din_d;

  logic                  ready, req, we, range_bad;
  logic [BYTE_W:0]       end_addr;

  assign end_addr  = {1'b0, addr_q} + {1'b0, byte_in};
  assign range_bad = (addr_q[BYTE_W-1:NODE_ADDR] != '0) || (end_addr > DEPTH);

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    err_d      = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    ready      = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (byte_valid && byte_in[BYTE_W-1:BYTE_W-4] == 4'hA) begin
          level_d = byte_in[3:0];
          state_d = H_ADDR;
        end
      end
      H_ADDR: begin
        ready = 1'b1;
        if (byte_valid) begin
          addr_d  = byte_in;
          state_d = H_CNT;
        end
      end
      H_CNT: begin
        ready = 1'b1;
        if (byte_valid) begin
          cnt_d   = byte_in;
          drain_d = 12'(byte_in) * 12'(BPW);
          idx_d   = '0;
          // Foreign or rejected frames still have their payload swallowed.
          if (level_q != 4'(LEVEL_ID)) begin
            state_d = (byte_in == '0) ? IDLE : DRAIN;
          end else if (range_bad) begin
            err_d   = 1'b1;
            state_d = (byte_in == '0) ? IDLE : DRAIN;
          end else if (byte_in == '0) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (update_gnt) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        req   = 1'b1;
        ready = update_gnt;
        if (byte_valid && update_gnt) begin
          word_d = {word_q[NODE_WIDTH-BYTE_W-1:0], byte_in};
          if (idx_q == 4'(BPW-1)) begin
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        req = 1'b1;
        if (update_gnt) begin
          we         = 1'b1;
          mem_addr_d = addr_q[NODE_ADDR-1:0];
          mem_din_d  = word_q;
          addr_d     = addr_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
          state_d    = (cnt_q == 1) ? DONE : PAYLOAD;
        end
      end
      DRAIN: begin
        ready = 1'b1;
        if (byte_valid) begin
          drain_d = drain_q - 1'b1;
          if (drain_q == 12'd1) state_d = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      level_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      drain_q    <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  // Outputs are forced low while reset is asserted, not just after the edge.
  assign byte_ready = RSTn & ready;
  assign update_req = RSTn & req;
  assign mem_we     = RSTn & we;
  assign mem_addr   = !RSTn ? '0 : (we ? addr_q[NODE_ADDR-1:0] : mem_addr_q);
  assign mem_din    = !RSTn ? '0 : (we ? word_q : mem_din_q);
  assign busy       = RSTn & (state_q != IDLE);
  assign load_done  = RSTn & (state_q == DONE);
  assign load_err   = RSTn & err_q;

endmodule

// File: tb/tb_tree_node_loader.sv
// Scoreboard bench for tree_node_loader: frames are modelled at issue time,
// a monitor pops expected writes/pulses as the DUT produces them.
module tb_tree_node_loader;
  localparam int LEVEL = 3;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        update_req;
  logic        update_gnt = 1'b1;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [39:0] mem_din;
  logic        busy, load_done, load_err;

  tree_node_loader #(.NODE_WIDTH(40), .NODE_ADDR(6), .BYTE_W(8), .LEVEL_ID(LEVEL)) dut (
    .clk(clk), .RSTn(RSTn), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .update_req(update_req), .update_gnt(update_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [39:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_ev[$];   // 1 = load_done, 2 = load_err
  int  total = 0, bad = 0;
  int  req_rises = 0;
  int  bytes_acc = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor samples 1 time unit before each rising edge.
  initial begin
    wr_t w;
    int  ev;
    forever begin
      @(negedge clk);
      #4;
      if (RSTn) begin
        if (mem_we) begin
          chk("write_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_addr, w.addr);
            chk("wr_data", mem_din, w.data);
          end
        end
        if (load_done) begin
          chk("done_expected", exp_ev.size() != 0, 1);
          if (exp_ev.size() != 0) begin
            ev = exp_ev.pop_front();
            chk("done_kind", ev, 1);
          end
          chk("req_low_at_done", update_req, 0);
        end
        if (load_err) begin
          chk("err_expected", exp_ev.size() != 0, 1);
          if (exp_ev.size() != 0) begin
            ev = exp_ev.pop_front();
            chk("err_kind", ev, 2);
          end
        end
        if (update_req && !update_gnt) begin
          chk("ready_without_gnt", byte_ready, 0);
          chk("we_without_gnt", mem_we, 0);
        end
        if (update_req && !prev_req) req_rises++;
        prev_req = update_req;
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int  tmo;
    logic ok;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    tmo = 0;
    forever begin
      #4;
      ok = byte_ready;
      @(negedge clk);
      if (ok) break;
      tmo++;
      if (tmo > 300) begin
        chk("byte_accept_timeout", tmo, 0);
        break;
      end
    end
    byte_valid = 1'b0;
    bytes_acc++;
  endtask

  // Reference model: decide the frame's fate, queue expected writes/pulses, then drive it.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] addr, input logic [7:0] n,
                           input int gap, input bit seq_payload);
    logic [7:0]  pay[$];
    logic [39:0] w;
    wr_t         e;
    int          r0, exp_r, k, tmo;
    bit          mine, err;
    mine  = (b0[7:4] == 4'hA) && (b0[3:0] == LEVEL);
    err   = (int'(addr) >= 64) || (int'(addr) + int'(n) > 64);
    exp_r = 0;
    for (int i = 0; i < int'(n) * 5; i++)
      pay.push_back(seq_payload ? 8'(i + 1) : 8'($urandom_range(0, 255)));
    if (mine) begin
      if (err) exp_ev.push_back(2);
      else begin
        k = 0;
        for (int i = 0; i < int'(n); i++) begin
          w = '0;
          for (int j = 0; j < 5; j++) begin
            w = (w << 8) | 40'(pay[k]);
            k++;
          end
          e.addr = 6'(int'(addr) + i);
          e.data = w;
          exp_wr.push_back(e);
        end
        exp_ev.push_back(1);
        if (n != 0) exp_r = 1;
      end
    end
    r0 = req_rises;
    send_byte(b0, gap);
    if (b0[7:4] == 4'hA) begin
      send_byte(addr, gap);
      send_byte(n, gap);
      foreach (pay[i]) send_byte(pay[i], gap);
    end
    tmo = 0;
    while (busy && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    repeat (2) @(negedge clk);
    chk("frame_idle", busy, 0);
    chk("writes_outstanding", exp_wr.size(), 0);
    chk("pulses_outstanding", exp_ev.size(), 0);
    chk("req_rises", req_rises - r0, exp_r);
  endtask

  task automatic wait_req(input int limit);
    int t;
    t = 0;
    while (!update_req && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", update_req, 1);
  endtask

  initial begin
    int b_start;
    logic [7:0] b0, a, n;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", update_req, 0);
    chk("rst_we", mem_we, 0);
    @(negedge clk);
    RSTn = 1'b1;
    #4;
    chk("idle_ready", byte_ready, 1);
    chk("idle_addr", mem_addr, 0);
    chk("idle_din", mem_din, 0);
    @(negedge clk);

    run_frame(8'hA3, 8'h10, 8'd2, 0, 1'b1);
    run_frame(8'hA5, 8'h00, 8'd1, 0, 1'b0);
    run_frame(8'hA3, 8'h3F, 8'd2, 0, 1'b0);
    run_frame(8'hA3, 8'h20, 8'd1, 0, 1'b0);

    // Grant withheld at request time, then dropped while a word waits in WRITE.
    update_gnt = 1'b0;
    b_start = bytes_acc;
    fork
      run_frame(8'hA3, 8'h08, 8'd2, 0, 1'b0);
      begin
        wait_req(100);
        repeat (20) @(negedge clk);
        update_gnt = 1'b1;
        fork
          wait (bytes_acc >= b_start + 8);
          repeat (500) @(negedge clk);
        join_any
        disable fork;
        update_gnt = 1'b0;
        repeat (7) @(negedge clk);
        update_gnt = 1'b1;
      end
    join

    send_byte(8'h55, 0);
    run_frame(8'hA3, 8'h00, 8'd0, 0, 1'b0);
    run_frame(8'hA3, 8'h30, 8'd3, 3, 1'b0);

    // Reset mid-payload: partial word is dropped, nothing queued for it.
    send_byte(8'hA3, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    repeat (3) send_byte(8'($urandom_range(0, 255)), 0);
    RSTn = 1'b0;
    #4;
    chk("midrst_ready", byte_ready, 0);
    chk("midrst_req", update_req, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_din", mem_din, 0);
    chk("midrst_done", load_done, 0);
    chk("midrst_err", load_err, 0);
    @(negedge clk);
    RSTn = 1'b1;
    run_frame(8'hA3, 8'h04, 8'd1, 0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 9) == 0) b0 = 8'($urandom_range(0, 9) << 4) | 8'h3;
      else if ($urandom_range(0, 9) < 7) b0 = 8'hA3;
      else b0 = 8'hA0 | 8'($urandom_range(0, 15));
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(60, 200)) : 8'($urandom_range(0, 63));
      n = 8'($urandom_range(0, 4));
      run_frame(b0, a, n, $urandom_range(0, 2), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
